instruction_fetch: RTL and testbench

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the opcode control decoder. It owns the program counter, fetches one 32-bit instruction per request from instruction memory over a variable-latency req/ack handshake, and holds it for decode behind a valid/ready handshake. It drives the opcode field into the control decoder. It takes back the control decoder's Branch/Jump decisions and the ALU Zero flag to select the next PC.

---
 rtl/instruction_fetch.sv | 107 ++++++++++
 tb/tb_instruction_fetch.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack imem port, holds instr for decode.
// Optional fetch timeout with ERR state is enabled by defining IFETCH_TIMEOUT_EN.
module instruction_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        CLK,
   input  logic        Resetb,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  Opcode,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        Branch,
   input  logic        Zero,
   input  logic        Jump,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   logic [1:0]  state;
   logic [31:0] next_pc;
   logic        timed_out;

   // Jump wins over a taken branch; everything wraps modulo 2^32.
   function automatic logic [31:0] next_pc_f(
      input logic [31:0] pc4,
      input logic [31:0] ins,
      input logic        br,
      input logic        zf,
      input logic        jmp
   );
      logic signed [31:0] off;
      off = {{14{ins[15]}}, ins[15:0], 2'b00};
      if (jmp)
         return {pc4[31:28], ins[25:0], 2'b00};
      else if (br && zf)
         return pc4 + $unsigned(off);
      else
         return pc4;
   endfunction

   assign pc_plus4    = pc + 32'd4;
   assign imem_addr   = pc;
   assign Opcode      = instr[31:26];
   assign imem_req    = (state == REQ);
   assign instr_valid = (state == HOLD);
   assign next_pc     = next_pc_f(pc_plus4, instr, Branch, Zero, Jump);

`ifdef IFETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wait_cnt;

   // Cleared whenever not requesting, so every entry to REQ starts from zero.
   always_ff @(posedge CLK or negedge Resetb) begin
      if (!Resetb)
         wait_cnt <= '0;
      else if (state != REQ)
         wait_cnt <= '0;
      else if (!imem_ack)
         wait_cnt <= wait_cnt + 1'b1;
   end

   assign timed_out = (wait_cnt == CW'(TIMEOUT - 1));
   assign fetch_err = (state == ERR);
`else
   assign timed_out = 1'b0;
   assign fetch_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge Resetb) begin
      if (!Resetb) begin
         state <= IDLE;
         pc    <= RESET_PC;
         instr <= 32'h0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (imem_ack) begin
                  instr <= imem_rdata;
                  state <= HOLD;
               end else if (timed_out) begin
                  state <= ERR;
               end
            end
            HOLD: begin
               if (instr_ready) begin
                  pc    <= next_pc;
                  state <= REQ;
               end
            end
            default: state <= state;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized self-checking bench for instruction_fetch against a transaction-level fetch model.
module tb_instruction_fetch;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          TMO    = 16;

   logic        CLK = 1'b0;
   logic        Resetb = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic [31:0] instr;
   logic [5:0]  Opcode;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic        Jump = 1'b0;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        fetch_err;

   int n_cmp = 0;
   int n_bad = 0;

   // model: phase 0 idle, 1 waiting for memory, 2 holding for decode, 3 error
   int          m_ph = 0;
   logic [31:0] m_pc = RST_PC;
   logic [31:0] m_instr = 32'h0;
   int          m_wait = 0;

   instruction_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .Resetb(Resetb), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .Opcode(Opcode),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .Branch(Branch),
      .Zero(Zero), .Jump(Jump), .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] ins,
                                            input bit b, input bit z, input bit j);
      logic [31:0] p4;
      int          off;
      p4  = p + 32'd4;
      off = int'($signed(ins[15:0])) * 4;
      if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      if (b && z) return p4 + 32'(off);
      return p4;
   endfunction

   task automatic check_outputs();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_ph == 1});
      chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_ph == 2});
      chk("fetch_err", {31'b0, fetch_err}, {31'b0, m_ph == 3});
      chk("pc", pc, m_pc);
      chk("imem_addr", imem_addr, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("instr", instr, m_instr);
      chk("Opcode", {26'b0, Opcode}, m_instr >> 26);
   endtask

   // Called at a falling edge: check, drive, advance the model, wait one cycle.
   task automatic step(input bit ack, input logic [31:0] rd, input bit rdy,
                       input bit b, input bit z, input bit j);
      check_outputs();
      imem_ack = ack; imem_rdata = rd; instr_ready = rdy;
      Branch = b; Zero = z; Jump = j;
      case (m_ph)
         0: begin m_ph = 1; m_wait = 0; end
         1: begin
            if (ack) begin
               m_instr = rd; m_ph = 2;
            end else begin
               m_wait++;
`ifdef IFETCH_TIMEOUT_EN
               if (m_wait == TMO) m_ph = 3;
`endif
            end
         end
         2: if (rdy) begin
            m_pc = ref_next(m_pc, m_instr, b, z, j);
            m_ph = 1; m_wait = 0;
         end
         default: ;
      endcase
      @(negedge CLK);
   endtask

   // One fetch/decode transaction with given memory and consumer delays.
   task automatic xact(input logic [31:0] rd, input bit b, input bit z, input bit j,
                       input int ack_dly, input int rdy_dly);
      for (int k = 0; k < 4 && m_ph == 0; k++) step(0, 32'h0, 0, 0, 0, 0);
      for (int k = 0; k < ack_dly; k++) step(0, $urandom, 0, 0, 0, 0);
      step(1, rd, 0, 0, 0, 0);
      for (int k = 0; k < rdy_dly; k++) step($urandom_range(0, 1), $urandom, 0,
                                              $urandom_range(0, 1), $urandom_range(0, 1), 0);
      step(0, 32'h0, 1, b, z, j);
   endtask

   task automatic apply_reset();
      #2 Resetb = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rst_async_req", {31'b0, imem_req}, 32'd0);
      chk("rst_async_valid", {31'b0, instr_valid}, 32'd0);
      repeat (2) @(negedge CLK);
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, 32'h0);
      chk("rst_err", {31'b0, fetch_err}, 32'd0);
      imem_ack = 1'b0;
      m_ph = 0; m_pc = RST_PC; m_instr = 32'h0; m_wait = 0;
      Resetb = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      chk("reset_req", {31'b0, imem_req}, 32'd0);
      chk("reset_valid", {31'b0, instr_valid}, 32'd0);
      chk("reset_pc", pc, RST_PC);
      chk("reset_opcode", {26'b0, Opcode}, 32'd0);
      Resetb = 1'b1;

      // linear fetch up to a request at 0x20
      for (int i = 0; i < 8; i++) xact($urandom, 0, 0, 0, 0, 0);
      chk("at_0x20", imem_addr, 32'h20);
      chk("req_before_reset", {31'b0, imem_req}, 32'd1);
      apply_reset();
      step(0, 32'h0, 0, 0, 0, 0);
      chk("restart_addr", imem_addr, RST_PC);
      chk("restart_req", {31'b0, imem_req}, 32'd1);

      // redirects
      xact(32'h0800_0040, 0, 0, 1, 0, 0);
      chk("jump_to_100", imem_addr, 32'h100);
      xact(32'h1000_FFFF, 1, 1, 0, 0, 0);
      chk("branch_taken", imem_addr, 32'h100);
      xact(32'h1000_FFFF, 1, 0, 0, 0, 0);
      chk("branch_not_taken", imem_addr, 32'h104);
      xact(32'h0800_0010, 1, 1, 1, 0, 0);
      chk("jump_priority", imem_addr, 32'h40);

      // wait states and backpressure
      xact(32'h1234_5678, 0, 0, 0, 3, 4);
      chk("backpressure_pc", imem_addr, 32'h44);

      // randomized traffic
      for (int i = 0; i < 800; i++)
         step($urandom_range(0, 1), $urandom, ($urandom_range(0, 9) < 6),
              $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));

      // withhold ack
      for (int k = 0; k < 4 && m_ph != 1; k++) step(0, 32'h0, 1, 0, 0, 0);
      for (int k = 0; k < TMO + 4; k++) step(0, $urandom, $urandom_range(0, 1), 0, 0, 0);
`ifdef IFETCH_TIMEOUT_EN
      chk("timeout_err", {31'b0, fetch_err}, 32'd1);
      chk("timeout_req", {31'b0, imem_req}, 32'd0);
      step(1, $urandom, 1, 0, 0, 0);
      chk("timeout_sticky", {31'b0, fetch_err}, 32'd1);
`else
      chk("no_timeout_err", {31'b0, fetch_err}, 32'd0);
      chk("no_timeout_req", {31'b0, imem_req}, 32'd1);
`endif
      apply_reset();
      step(0, 32'h0, 0, 0, 0, 0);
      chk("final_err_clear", {31'b0, fetch_err}, 32'd0);
      xact(32'h0, 0, 0, 0, 1, 1);
      check_outputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
